uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 164 ++++++++++++++++
 tb/tb_uart_rx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, mid-bit sampling.
// The serial line is asynchronous and passes through a two-flop synchronizer.
// A single FSM then tracks the start bit, the eight data bits and the stop bit.
// Each accepted byte is announced with a one-cycle rx_valid pulse.
// A low stop bit raises a one-cycle frame_err pulse instead.
// After a framing error the receiver waits for the line to return high.
// This stops a held-low break condition from looking like a stream of start bits.

module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err
);

    // Counter spans 0..CLKS_PER_BIT-1; half-bit point is used to validate the start bit.
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT / 2) - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_t;

    // Synchronizer stages: both reset to the idle-line level so reset never fakes a start bit.
    logic             sync1_r;
    logic             rx_s_r;

    // Receiver state.
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       idx_r;
    logic [7:0]       shift_r;

    // Registered outputs.
    logic [7:0]       rx_data_r;
    logic             rx_valid_r;
    logic             frame_err_r;

    // Two-flop synchronizer for the asynchronous serial input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            rx_s_r  <= 1'b1;
        end else begin
            sync1_r <= rx_serial;
            rx_s_r  <= sync1_r;
        end
    end

    // Frame FSM: bit timing, data capture and output pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            idx_r       <= 3'd0;
            shift_r     <= 8'h00;
            rx_data_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            // The pulse outputs default low, so each pulse lasts exactly one cycle.
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    // A falling edge on the synchronized line may be a start bit.
                    if (rx_s_r == 1'b0) begin
                        state_r <= ST_START;
                        cnt_r   <= CNT_ZERO;
                    end else begin
                        state_r <= ST_IDLE;
                        cnt_r   <= CNT_ZERO;
                    end
                end

                ST_START: begin
                    // Re-check the line at mid start bit.
                    // This also aligns later samples to the middle of each bit.
                    if (cnt_r == CNT_HALF) begin
                        cnt_r <= CNT_ZERO;
                        if (rx_s_r == 1'b0) begin
                            state_r <= ST_DATA;
                            idx_r   <= 3'd0;
                        end else begin
                            // Line went back high: glitch, drop it silently.
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                ST_DATA: begin
                    // One full bit period after mid start lands at mid data bit.
                    if (cnt_r == CNT_FULL) begin
                        cnt_r          <= CNT_ZERO;
                        shift_r[idx_r] <= rx_s_r;
                        if (idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                        end else begin
                            idx_r <= idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                ST_STOP: begin
                    // Mid stop bit decides between a good byte and a framing error.
                    if (cnt_r == CNT_FULL) begin
                        cnt_r <= CNT_ZERO;
                        if (rx_s_r == 1'b1) begin
                            rx_data_r  <= shift_r;
                            rx_valid_r <= 1'b1;
                            state_r    <= ST_IDLE;
                        end else begin
                            frame_err_r <= 1'b1;
                            state_r     <= ST_WAIT_HIGH;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end

                ST_WAIT_HIGH: begin
                    // A break holds the line low.
                    // Only a return to idle-high re-arms start detection.
                    cnt_r <= CNT_ZERO;
                    if (rx_s_r == 1'b1) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT_HIGH;
                    end
                end

                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                    idx_r   <= 3'd0;
                end
            endcase
        end
    end

    // Output wiring: busy is a direct decode of the state register.
    assign rx_busy   = (state_r != ST_IDLE);
    assign rx_data   = rx_data_r;
    assign rx_valid  = rx_valid_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx with CLKS_PER_BIT = 16.
// A linear stimulus sequence drives the serial line.
// A negedge monitor accumulates pulse counts and received bytes.

module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       rst;
    logic       rx_serial;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;

    int n_checks;
    int n_fail;

    int cyc;
    int valid_hi;
    int err_hi;
    int both_hi;
    int busy_hi;
    logic [7:0] vq[$];
    int         tq[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_serial (rx_serial),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_busy   (rx_busy),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle counter.
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            valid_hi <= valid_hi + 1;
            vq.push_back(rx_data);
            tq.push_back(cyc);
        end
        if (frame_err === 1'b1) err_hi <= err_hi + 1;
        if (rx_valid === 1'b1 && frame_err === 1'b1) both_hi <= both_hi + 1;
        if (rx_busy === 1'b1) busy_hi <= busy_hi + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx_serial = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            wait_clks(CPB);
        end
        rx_serial = stop_bit;
        wait_clks(CPB);
        rx_serial = 1'b1;
    endtask

    function automatic logic [7:0] byte_at(input int idx);
        if (idx < vq.size()) return vq[idx];
        else return 8'hxx;
    endfunction

    initial begin
        int v0, e0, b0, q0, gap;
        cyc = 0; valid_hi = 0; err_hi = 0; both_hi = 0; busy_hi = 0;
        n_checks = 0; n_fail = 0;
        rst = 1'b1;
        rx_serial = 1'b1;
        wait_clks(3);

        // Reset state.
        check("reset_rx_data",   32'(rx_data),   32'h00);
        check("reset_rx_valid",  32'(rx_valid),  32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_rx_busy",   32'(rx_busy),   32'h0);
        rst = 1'b0;
        wait_clks(10);

        // Single 0xA5 frame.
        v0 = valid_hi; e0 = err_hi; q0 = vq.size();
        send_frame(8'hA5, 1'b1);
        wait_clks(20);
        check("a5_valid_cycles", 32'(valid_hi - v0), 32'd1);
        check("a5_data",         32'(byte_at(q0)),   32'hA5);
        check("a5_rx_data",      32'(rx_data),       32'hA5);
        check("a5_no_err",       32'(err_hi - e0),   32'd0);
        check("a5_busy_low",     32'(rx_busy),       32'h0);

        // Back-to-back 0xA5 then 0x3C.
        v0 = valid_hi; q0 = vq.size();
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        wait_clks(20);
        check("b2b_valid_cycles", 32'(valid_hi - v0),   32'd2);
        check("b2b_first",        32'(byte_at(q0)),     32'hA5);
        check("b2b_second",       32'(byte_at(q0 + 1)), 32'h3C);
        gap = (tq.size() > q0 + 1) ? (tq[q0 + 1] - tq[q0]) : 0;
        check("b2b_spacing_158_162", 32'(gap >= 158 && gap <= 162), 32'd1);

        // 4-clk glitch on the idle line.
        v0 = valid_hi; e0 = err_hi; b0 = busy_hi;
        rx_serial = 1'b0;
        wait_clks(4);
        rx_serial = 1'b1;
        wait_clks(30);
        check("glitch_busy_1_to_10", 32'((busy_hi - b0) >= 1 && (busy_hi - b0) <= 10), 32'd1);
        check("glitch_no_valid",     32'(valid_hi - v0), 32'd0);
        check("glitch_no_err",       32'(err_hi - e0),   32'd0);

        // Framing error with a held-low break, then a clean frame.
        q0 = vq.size();
        send_frame(8'hA5, 1'b1);
        wait_clks(20);
        v0 = valid_hi; e0 = err_hi;
        send_frame(8'h3C, 1'b0);
        rx_serial = 1'b0;
        wait_clks(50);
        check("ferr_err_cycles",  32'(err_hi - e0),   32'd1);
        check("ferr_no_valid",    32'(valid_hi - v0), 32'd0);
        check("ferr_data_kept",   32'(rx_data),       32'hA5);
        check("ferr_busy_held",   32'(rx_busy),       32'h1);
        rx_serial = 1'b1;
        wait_clks(6);
        check("ferr_busy_release", 32'(rx_busy),      32'h0);
        q0 = vq.size();
        send_frame(8'h3C, 1'b1);
        wait_clks(20);
        check("ferr_recover_valid", 32'(valid_hi - v0), 32'd1);
        check("ferr_recover_data",  32'(byte_at(q0)),   32'h3C);
        check("ferr_recover_noerr", 32'(err_hi - e0),   32'd1);

        // Reset during data bit 3 of an 0xF8 frame; the remaining line stays high.
        v0 = valid_hi; e0 = err_hi;
        rx_serial = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 3; i++) begin
            rx_serial = 1'b0;
            wait_clks(CPB);
        end
        rx_serial = 1'b1;
        wait_clks(8);
        check("pre_rst_busy", 32'(rx_busy), 32'h1);
        rst = 1'b1;
        wait_clks(1);
        check("rst_rx_data",   32'(rx_data),   32'h00);
        check("rst_rx_valid",  32'(rx_valid),  32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_rx_busy",   32'(rx_busy),   32'h0);
        rst = 1'b0;
        wait_clks(100);
        check("abort_no_valid", 32'(valid_hi - v0), 32'd0);
        check("abort_no_err",   32'(err_hi - e0),   32'd0);
        q0 = vq.size();
        send_frame(8'h55, 1'b1);
        wait_clks(20);
        check("post_rst_valid", 32'(valid_hi - v0), 32'd1);
        check("post_rst_data",  32'(byte_at(q0)),   32'h55);
        check("post_rst_rx_data", 32'(rx_data),     32'h55);

        // Exclusivity of the two pulses across the whole run.
        check("never_both_pulses", 32'(both_hi), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
